// File: rtl/pe_io_pkg.sv
// Shared sizing helpers for the PE operand I/O blocks.
//   ptr_w(depth) : bits needed for a pointer into a depth-entry array (at least 1)
//   cnt_w(depth) : bits needed for an occupancy count from 0 to depth
//   PE_OPND_T(w) : declares the operand word type opnd_t, w bits wide, in the
//                  scope where the macro is used (width is a module parameter)
package pe_io_pkg;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`ifndef PE_OPND_T
`define PE_OPND_T(w) typedef logic [(w)-1:0] opnd_t;
`endif

// File: rtl/pe_fifo_ptr.sv
// Modulo-DEPTH pointer counter. DEPTH does not have to be a power of two;
// the pointer returns to 0 after it reaches DEPTH-1.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the pointer to 0
//   en_i  : advance the pointer by one this cycle
//   ptr_o : current pointer value
module pe_fifo_ptr
    import pe_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    output logic [ptr_w(DEPTH)-1:0]  ptr_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pe_operand_stage_fifo.sv
// Elastic operand stage in front of the PE wire-through input port. Buffers
// up to DEPTH operand words from the L2 read path and presents the oldest one
// (with a valid flag) to the port's d input.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset; discards all buffered words
//   in_vld  : upstream word valid
//   in_rdy  : stage can accept a word this cycle (depends on occupancy only)
//   in_dat  : upstream operand word
//   out_vld : head word valid
//   out_rdy : PE consumes the head word this cycle
//   out_dat : head word (don't-care while out_vld is low)
//   count   : current occupancy
// rscid is a tool bookkeeping id and has no functional effect.
module pe_operand_stage_fifo
    import pe_io_pkg::*;
#(
    parameter int rscid = 1,
    parameter int width = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [width-1:0]         in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [width-1:0]         out_dat,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    `PE_OPND_T(width)

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (width < 1 || DEPTH < 2 || rscid < 0) begin : g_bad_params
        $error("pe_operand_stage_fifo: illegal parameter values");
    end

    opnd_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flags come from the registered count only, so in_rdy never depends on
    // out_rdy and a word written this cycle is not visible until next cycle.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = in_vld & ~full;
    assign pop   = out_rdy & ~empty;

    pe_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push),
        .ptr_o (wr_ptr)
    );

    pe_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

    // Storage is deliberately not reset; a write during reset is harmless
    // because both pointers and the count return to zero on the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= in_dat;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_rdy  = ~full;
    assign out_vld = ~empty;
    assign out_dat = mem_q[rd_ptr];
    assign count   = count_q;

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C)
        else $error("pe_operand_stage_fifo: count exceeds DEPTH");

endmodule

// File: tb/tb_pe_operand_stage_fifo.sv
module tb_pe_operand_stage_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_dat;
    logic       out_rdy;

    logic       in_rdy4, out_vld4;
    logic [7:0] out_dat4;
    logic [2:0] count4;
    logic       in_rdy3, out_vld3;
    logic [7:0] out_dat3;
    logic [1:0] count3;

    always #5 clk = ~clk;

    pe_operand_stage_fifo #(.rscid(1), .width(8), .DEPTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy4),
        .in_dat  (in_dat),
        .out_vld (out_vld4),
        .out_rdy (out_rdy),
        .out_dat (out_dat4),
        .count   (count4)
    );

    pe_operand_stage_fifo #(.rscid(2), .width(8), .DEPTH(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy3),
        .in_dat  (in_dat),
        .out_vld (out_vld3),
        .out_rdy (out_rdy),
        .out_dat (out_dat3),
        .count   (count3)
    );

    int errors = 0;
    int checks = 0;

    // Reference contents of each FIFO, oldest word first.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         model_ok = 1'b0;
    bit         collect3 = 1'b0;
    logic [7:0] pop3[$];

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       rd;
        int         cnt;
        logic       ov;
        logic       ir;
        logic       chkd;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m4_count",   32'(count4),  32'(q4.size()));
        chk("m4_out_vld", 32'(out_vld4), 32'(q4.size() != 0));
        chk("m4_in_rdy",  32'(in_rdy4),  32'(q4.size() != 4));
        if (q4.size() > 0) chk("m4_out_dat", 32'(out_dat4), 32'(q4[0]));
        chk("m3_count",   32'(count3),  32'(q3.size()));
        chk("m3_out_vld", 32'(out_vld3), 32'(q3.size() != 0));
        chk("m3_in_rdy",  32'(in_rdy3),  32'(q3.size() != 3));
        if (q3.size() > 0) chk("m3_out_dat", 32'(out_dat3), 32'(q3[0]));
    endtask

    // Apply one cycle of stimulus to both instances. Outputs are compared to
    // the reference just before the edge (with the new inputs already applied,
    // so any combinational dependency on inputs shows up), then the reference
    // applies the transfer rules and the clock advances.
    task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic rd);
        bit p, o;
        rst = r; in_vld = v; in_dat = d; out_rdy = rd;
        #1;
        if (model_ok) begin
            model_check();
            if (collect3 && rd && out_vld3) pop3.push_back(out_dat3);
        end
        if (r) begin
            q4.delete();
            q3.delete();
            model_ok = 1'b1;
        end else begin
            p = v && (q4.size() < 4);
            o = rd && (q4.size() > 0);
            if (o) void'(q4.pop_front());
            if (p) q4.push_back(d);
            p = v && (q3.size() < 3);
            o = rd && (q3.size() > 0);
            if (o) void'(q3.pop_front());
            if (p) q3.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic v, input logic [7:0] d, input logic rd,
                                input int cnt, input logic ov, input logic ir,
                                input logic chkd, input logic [7:0] dat);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.rd = rd;
        e.cnt = cnt; e.ov = ov; e.ir = ir; e.chkd = chkd; e.dat = dat;
        tbl.push_back(e);
    endfunction

    initial begin
        int bias;

        // Expected values below are for the DEPTH=4 instance, after each edge.
        // Reset held two cycles with upstream valid.
        add(1, 1, 8'hAA, 0, 0, 0, 1, 0, 8'h00);
        add(1, 1, 8'hAA, 0, 0, 0, 1, 0, 8'h00);
        // Fill 01..04, then drain.
        add(0, 1, 8'h01, 0, 1, 1, 1, 1, 8'h01);
        add(0, 1, 8'h02, 0, 2, 1, 1, 1, 8'h01);
        add(0, 1, 8'h03, 0, 3, 1, 1, 1, 8'h01);
        add(0, 1, 8'h04, 0, 4, 1, 0, 1, 8'h01);
        add(0, 0, 8'h00, 1, 3, 1, 1, 1, 8'h02);
        add(0, 0, 8'h00, 1, 2, 1, 1, 1, 8'h03);
        add(0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h04);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        // Refill to full, then push 55 while full and popping.
        add(0, 1, 8'hA0, 0, 1, 1, 1, 1, 8'hA0);
        add(0, 1, 8'hA1, 0, 2, 1, 1, 1, 8'hA0);
        add(0, 1, 8'hA2, 0, 3, 1, 1, 1, 8'hA0);
        add(0, 1, 8'hA3, 0, 4, 1, 0, 1, 8'hA0);
        add(0, 1, 8'h55, 1, 3, 1, 1, 1, 8'hA1);
        add(0, 1, 8'h55, 0, 4, 1, 0, 1, 8'hA1);
        // Drop to two words (A3, 55), then stream 10 words.
        add(0, 0, 8'h00, 1, 3, 1, 1, 1, 8'hA2);
        add(0, 0, 8'h00, 1, 2, 1, 1, 1, 8'hA3);
        for (int k = 1; k <= 10; k++) begin
            add(0, 1, 8'(8'h10 + k - 1), 1, 2, 1, 1, 1,
                (k == 1) ? 8'h55 : 8'(8'h10 + k - 2));
        end
        // Third word, then reset with valid and ready both high.
        add(0, 1, 8'h20, 0, 3, 1, 1, 1, 8'h18);
        add(1, 1, 8'h21, 1, 0, 0, 1, 0, 8'h00);
        add(0, 1, 8'hE7, 0, 1, 1, 1, 1, 8'hE7);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rd);
            chk("tbl_count",   32'(count4),   32'(tbl[i].cnt));
            chk("tbl_out_vld", 32'(out_vld4), 32'(tbl[i].ov));
            chk("tbl_in_rdy",  32'(in_rdy4),  32'(tbl[i].ir));
            if (tbl[i].chkd) chk("tbl_out_dat", 32'(out_dat4), 32'(tbl[i].dat));
        end

        // Wrap on the DEPTH=3 instance: C0..C6 interleaved push/pop.
        drive(1, 0, 8'h00, 0);
        collect3 = 1'b1;
        drive(0, 1, 8'hC0, 0);
        drive(0, 1, 8'hC1, 0);
        for (int k = 2; k <= 6; k++) drive(0, 1, 8'(8'hC0 + k), 1);
        for (int k = 0; k < 3; k++) drive(0, 0, 8'h00, 1);
        collect3 = 1'b0;
        chk("wrap_pop_count", 32'(pop3.size()), 32'd7);
        for (int k = 0; k < 7; k++) begin
            chk("wrap_order", (k < pop3.size()) ? 32'(pop3[k]) : 32'hFFFF_FFFF, 32'(8'hC0 + k));
        end

        // Randomized traffic with occasional resets, checked by the reference.
        bias = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) bias = (n / 100 % 3 == 0) ? 20 : ((n / 100 % 3 == 1) ? 80 : 50);
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < bias));
        end
        model_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
